demux10_router: RTL and testbench
=================================

// Module: demux10_router
// PURPOSE
//  1-to-10 streaming demultiplexer: the distribution counterpart of the 10:1 select tree.
//  Routes one valid/ready input stream to one of 10 output channels chosen per beat by in_sel.
//  Each channel has a one-entry output register, so a stalled channel does not block
//  traffic to the other channels.
//  Out-of-range selects (10..15) are consumed, dropped and counted.
// PARAMETERS
//  DATA_W  8  payload width per beat
//  CNT_W   8  width of saturating drop counter
// PORTS
//  clk        in   1          single clock; all state updates on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   1          input beat present
//  in_ready   out  1          input beat accepted this cycle when in_valid&in_ready
//  in_data    in   DATA_W     input payload
//  in_sel     in   4          destination channel 0..9; 10..15 = invalid
//  out_valid  out  10         per-channel beat present
//  out_ready  in   10         per-channel sink ready
//  out_data   out  10*DATA_W  channel i payload at [i*DATA_W +: DATA_W]
//  drop_cnt   out  CNT_W      count of dropped beats, saturating
//  err_pulse  out  1          1-cycle pulse, registered, for each dropped beat
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//   - out_valid=0, out_data=0, drop_cnt=0, err_pulse=0.
//   - Any beat held in a channel register is discarded. Reset mid-transfer loses no state beyond this.
//  in_ready (combinational from in_sel, out_valid, out_ready; no dependency on in_valid):
//   - in_sel>=10: in_ready=1.
//   - else: in_ready = ~out_valid[in_sel] | out_ready[in_sel].
//  Accept = in_valid & in_ready.
//   - Latency is 1 cycle: a beat accepted at edge k gives out_valid[sel]=1 with its data after edge k.
//  Per-channel register i, evaluated each edge:
//   - load  = accept & (in_sel==i).
//   - drain = out_valid[i] & out_ready[i].
//   - load (with or without drain): out_valid[i]=1, out_data[i]=in_data. Full throughput, 1 beat/cycle.
//   - drain & ~load: out_valid[i]=0. out_data[i] holds its last value.
//   - neither: hold.
//   - While out_valid[i]=1 and out_ready[i]=0, out_data[i] is stable.
//  Channels are independent:
//   - All 10 may drain in the same cycle.
//   - Only the selected channel can load.
//  Invalid select (accept & in_sel>=10):
//   - Beat discarded; no out_valid change.
//   - drop_cnt += 1, saturating at 2^CNT_W-1 (no wrap).
//   - err_pulse=1 for the following cycle only. Back-to-back drops keep err_pulse high.
//  in_valid=0: no state change except drains. in_sel and in_data are don't-care.
// TESTING
//  1. Assert rst_n=0 with random inputs -> out_valid=0, out_data=0, drop_cnt=0, err_pulse=0.
//  2. out_ready=all-1; send 0xA5 with sel=3 -> cycle+1: out_valid=10'b0000001000,
//     out_data[3]=0xA5; cycle+2: out_valid=0.
//  3. out_ready[7]=0; send 0x11 then 0x22 to sel=7:
//     - 0x11 accepted; in_ready=0 while 0x22 is offered; out_data[7] stays 0x11.
//     - Meanwhile 0x33 to sel=2 is accepted.
//     - Raise out_ready[7] -> 0x22 is accepted the same cycle, out_data[7]=0x22 next cycle.
//  4. Channel 0, out_ready[0]=1, back-to-back 0x01,0x02,0x03 -> in_ready stays 1 and
//     out_data[0] shows 01,02,03 on consecutive cycles.
//  5. Send sel=12 three times -> in_ready=1; no out_valid; drop_cnt=3; err_pulse high 3 cycles.
//     With CNT_W=2, 5 drops -> drop_cnt=3 (saturated).
//  6. Fill ch 4 and ch 9 with out_ready=0, pulse rst_n low mid-cycle -> out_valid=0
//     immediately (async); after release, a new send to ch 4 works normally.

Source files
------------

// File: rtl/demux10_router.sv
// 1-to-10 valid/ready stream demultiplexer with a one-entry register per channel.
// Beats with an out-of-range select are consumed, dropped and counted.
module demux10_router #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [3:0]           in_sel,
    output logic [9:0]           out_valid,
    input  logic [9:0]           out_ready,
    output logic [10*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 err_pulse
);
    localparam int NCH = 10;

    logic [NCH-1:0]    sel_hot;
    logic [NCH-1:0]    room;
    logic [NCH-1:0]    valid_reg;
    logic [DATA_W-1:0] data_reg [NCH];
    logic [CNT_W-1:0]  drop_cnt_reg;
    logic              err_reg;
    logic              sel_ok;
    logic              accept;
    logic              drop;

    // One-hot decode keeps the ready mux in range for selects 10..15.
    assign sel_ok   = |sel_hot;
    assign in_ready = ~sel_ok | (|(sel_hot & room));
    assign accept   = in_valid & in_ready;
    assign drop     = accept & ~sel_ok;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [3:0] CH = gi;

            assign sel_hot[gi] = (in_sel == CH);
            // A full channel can still take a beat in the cycle it drains.
            assign room[gi]    = ~valid_reg[gi] | out_ready[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                end else if (accept && sel_hot[gi]) begin
                    valid_reg[gi] <= 1'b1;
                    data_reg[gi]  <= in_data;
                end else if (valid_reg[gi] && out_ready[gi]) begin
                    valid_reg[gi] <= 1'b0;
                end
            end

            assign out_data[gi*DATA_W +: DATA_W] = data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= drop;
            if (drop && drop_cnt_reg != {CNT_W{1'b1}}) begin
                drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign out_valid = valid_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign err_pulse = err_reg;
endmodule

// File: tb/tb_demux10_router.sv
// Bench for demux10_router: directed stimulus, abstract channel model checked every cycle,
// plus literal expectations; a second instance with a 2-bit counter checks saturation.
module tb_demux10_router;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [7:0]  in_data;
    logic [3:0]  in_sel;
    logic [9:0]  out_valid, out_valid2;
    logic [9:0]  out_ready;
    logic [79:0] out_data, out_data2;
    logic [7:0]  drop_cnt;
    logic [1:0]  drop_cnt2;
    logic        err_pulse, err_pulse2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux10_router #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .drop_cnt(drop_cnt), .err_pulse(err_pulse)
    );

    demux10_router #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .drop_cnt(drop_cnt2), .err_pulse(err_pulse2)
    );

    // Abstract model: each channel is a slot that is either empty or holds a byte.
    bit       m_full [10];
    bit [7:0] m_byte [10];
    int       m_drops;
    bit       m_err;

    function automatic bit model_ready();
        if (in_sel >= 4'd10) return 1'b1;
        return !m_full[in_sel] || out_ready[in_sel];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) begin
                m_full[i] = 1'b0;
                m_byte[i] = 8'h00;
            end
            m_drops = 0;
            m_err   = 1'b0;
        end else begin
            bit acc;
            acc = in_valid && model_ready();
            for (int i = 0; i < 10; i++)
                if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
            m_err = acc && (in_sel >= 4'd10);
            if (m_err) m_drops++;
            else if (acc) begin
                m_full[in_sel] = 1'b1;
                m_byte[in_sel] = in_data;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0]  ev;
        logic [79:0] ed;
        for (int i = 0; i < 10; i++) begin
            ev[i]         = m_full[i];
            ed[i*8 +: 8]  = m_byte[i];
        end
        chk("out_valid", out_valid, ev);
        chk("out_data", out_data, ed);
        chk("in_ready", in_ready, model_ready());
        chk("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
        chk("err_pulse", err_pulse, m_err);
        chk("out_valid2", out_valid2, ev);
        chk("in_ready2", in_ready2, model_ready());
        chk("drop_cnt2", drop_cnt2, (m_drops > 3) ? 3 : m_drops);
        chk("err_pulse2", err_pulse2, m_err);
        $display("cyc t=%0t rst_n=%b v=%b sel=%0d d=%02h rdy=%b ov=%b dc=%0d err=%b",
                 $time, rst_n, in_valid, in_sel, in_data, in_ready, out_valid, drop_cnt, err_pulse);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sel = 4'd0; in_data = 8'h00; out_ready = '0;
        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid = 1'($urandom); in_sel = 4'($urandom);
            in_data = 8'($urandom); out_ready = 10'($urandom);
        end
        chk("rst_valid", out_valid, 10'd0);
        chk("rst_data", out_data, 80'd0);
        chk("rst_cnt", drop_cnt, 8'd0);
        chk("rst_err", err_pulse, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b1; in_valid = 1'b0;
        step();

        // 2: single beat to channel 3
        out_ready = 10'h3FF; in_valid = 1'b1; in_sel = 4'd3; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        chk("t2_valid", out_valid, 10'b0000001000);
        chk("t2_data", out_data[3*8 +: 8], 8'hA5);
        step();
        chk("t2_drain", out_valid, 10'd0);

        // 3: stalled channel 7 does not block channel 2
        out_ready = 10'b1101111111;
        in_valid = 1'b1; in_sel = 4'd7; in_data = 8'h11;
        step();
        in_data = 8'h22; #1;
        chk("t3_stall_rdy", in_ready, 1'b0);
        step();
        chk("t3_hold", out_data[7*8 +: 8], 8'h11);
        in_sel = 4'd2; in_data = 8'h33; #1;
        chk("t3_ch2_rdy", in_ready, 1'b1);
        step();
        chk("t3_ch2_data", out_data[2*8 +: 8], 8'h33);
        in_sel = 4'd7; in_data = 8'h22; out_ready[7] = 1'b1; #1;
        chk("t3_unstall_rdy", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("t3_ch7_data", out_data[7*8 +: 8], 8'h22);
        step();

        // 4: back-to-back on channel 0
        for (int d = 1; d <= 3; d++) begin
            in_valid = 1'b1; in_sel = 4'd0; in_data = 8'(d); #1;
            chk("t4_rdy", in_ready, 1'b1);
            step();
            chk("t4_data", out_data[7:0], 8'(d));
        end
        in_valid = 1'b0;
        step();

        // 5: invalid selects are dropped and counted
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1; in_sel = 4'd12; in_data = 8'(k); #1;
            chk("t5_rdy", in_ready, 1'b1);
            step();
            chk("t5_err", err_pulse, 1'b1);
            chk("t5_cnt", drop_cnt, 8'(k));
            chk("t5_novalid", out_valid, 10'd0);
        end
        chk("t5_sat2", drop_cnt2, 2'd3);
        in_valid = 1'b0;
        step();
        chk("t5_err_low", err_pulse, 1'b0);

        // 6: async reset while channels 4 and 9 are full
        out_ready = '0;
        in_valid = 1'b1; in_sel = 4'd4; in_data = 8'h44;
        step();
        in_sel = 4'd9; in_data = 8'h99;
        step();
        in_valid = 1'b0;
        chk("t6_full", out_valid, 10'b1000010000);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 10'd0);
        chk("t6_async_cnt", drop_cnt, 8'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        step();
        out_ready = 10'h3FF; in_valid = 1'b1; in_sel = 4'd4; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        chk("t6_after_valid", out_valid, 10'b0000010000);
        chk("t6_after_data", out_data[4*8 +: 8], 8'h5A);
        step();

        // Mixed traffic with shifting backpressure, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            in_valid  = (i % 3) != 0;
            in_sel    = 4'((i * 7) % 16);
            in_data   = 8'(i * 13 + 5);
            out_ready = 10'((i * 10'h2B5) ^ (i << 3));
            step();
        end
        in_valid = 1'b0; out_ready = 10'h3FF;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
